// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared width default, FSM states and bin-to-Gray helper
package gray_pkg;

  localparam int GRAY_DEFAULT_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gray_state_e;

  // Sized for the widest legal code; callers cast to their own width.
  function automatic logic [15:0] bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_source_if.sv
// rtl/gray_counter_source_if.sv - Gray code offer/accept link to the downstream stage
interface gray_counter_source_if #(
  parameter int N = gray_pkg::GRAY_DEFAULT_N
);

  logic [N-1:0] gray;
  logic         out_valid;
  logic         out_ready;
  logic         wrap;

  modport master (output gray, output out_valid, output wrap, input out_ready);
  modport slave  (input gray, input out_valid, input wrap, output out_ready);

endinterface

// File: rtl/bin_to_gray.sv
// rtl/bin_to_gray.sv - combinational binary to Gray conversion
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int N = GRAY_DEFAULT_N
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = N'(bin2gray(16'(bin_i)));

endmodule

// File: rtl/gray_counter_source.sv
// rtl/gray_counter_source.sv - up/down Gray code source with load, backpressure and wrap pulse
module gray_counter_source
  import gray_pkg::*;
#(
  parameter int N = GRAY_DEFAULT_N
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [N-1:0]                  load_bin,
  gray_counter_source_if.master         bus
);

  gray_state_e  state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;

  logic out_valid;
  logic xfer;
  logic load_ok;

  assign out_valid = (state_q == ST_RUN);
  assign xfer      = out_valid & bus.out_ready;
  // A load may not replace a code that is on offer but not yet taken.
  assign load_ok   = load & (~out_valid | xfer);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load_ok) begin
      cnt_d = load_bin;
    end else if (xfer) begin
      if (up) begin
        cnt_d  = cnt_q + N'(1);
        wrap_d = (cnt_q == {N{1'b1}});
      end else begin
        cnt_d  = cnt_q - N'(1);
        wrap_d = (cnt_q == '0);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)         state_d = ST_RUN;
      ST_RUN:  if (xfer & ~en) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  bin_to_gray #(.N(N)) u_bin_to_gray (
    .bin_i  (cnt_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.gray      = gray_q;
  assign bus.out_valid = out_valid;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_source.sv
// tb/tb_gray_counter_source.sv - directed vector bench for gray_counter_source
module tb_gray_counter_source;

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] bin;
    logic       rdy;
    logic [3:0] g;
    logic       v;
    logic       w;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_bin = 4'd0;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  logic [3:0] up_codes [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_counter_source_if #(.N(4)) bus ();

  gray_counter_source #(.N(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic e, input logic u, input logic l, input logic [3:0] b,
                     input logic r, input logic [3:0] g, input logic v, input logic w);
    vec_t t;
    t.en = e; t.up = u; t.ld = l; t.bin = b; t.rdy = r; t.g = g; t.v = v; t.w = w;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic v, input logic w);
    checks++;
    if (bus.gray !== g) begin
      errors++;
      $display("FAIL %s gray: got %b want %b", name, bus.gray, g);
    end
    checks++;
    if (bus.out_valid !== v) begin
      errors++;
      $display("FAIL %s out_valid: got %b want %b", name, bus.out_valid, v);
    end
    checks++;
    if (bus.wrap !== w) begin
      errors++;
      $display("FAIL %s wrap: got %b want %b", name, bus.wrap, w);
    end
  endtask

  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] b,
                      input logic r);
    en = e; up = u; load = l; load_bin = b; bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; up = 1'b1; load = 1'b0; load_bin = 4'd0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;

    // up-count, wrap, backpressure, en drop, loads
    add(1, 1, 0, 0, 1, 4'b0000, 1, 0);
    for (int k = 1; k < 16; k++) add(1, 1, 0, 0, 1, up_codes[k], 1, 0);
    add(1, 1, 0, 0, 1, 4'b0000, 1, 1);
    add(1, 1, 0, 0, 1, 4'b0001, 1, 0);
    add(1, 1, 0, 0, 1, 4'b0011, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, 4'b0011, 1, 0);
    add(1, 1, 0, 0, 1, 4'b0010, 1, 0);
    add(0, 1, 0, 0, 0, 4'b0010, 1, 0);
    add(0, 1, 0, 0, 1, 4'b0110, 0, 0);
    add(0, 1, 0, 0, 1, 4'b0110, 0, 0);
    add(0, 1, 1, 9, 0, 4'b1101, 0, 0);
    add(1, 1, 0, 0, 0, 4'b1101, 1, 0);
    add(1, 1, 1, 5, 1, 4'b0111, 1, 0);
    add(1, 1, 1, 0, 0, 4'b0111, 1, 0);
    add(1, 1, 0, 0, 1, 4'b0101, 1, 0);
    add(1, 1, 1, 15, 1, 4'b1000, 1, 0);
    add(1, 1, 1, 3, 1, 4'b0010, 1, 0);
    add(1, 0, 1, 15, 1, 4'b1000, 1, 0);
    add(1, 0, 0, 0, 1, 4'b1001, 1, 0);
    add(0, 0, 1, 0, 1, 4'b0000, 0, 0);

    do_reset();
    check("reset", 4'b0000, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].bin, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].v, vecs[i].w);
    end

    // down-count with wrap, then reset landing on a live wrap pulse
    do_reset();
    step(1, 0, 0, 0, 1); check("down0", 4'b0000, 1, 0);
    step(1, 0, 0, 0, 1); check("down15", 4'b1000, 1, 1);
    #2 rst = 1'b1;
    #1 check("rst_on_wrap", 4'b0000, 0, 0);
    #1 rst = 1'b0;
    step(1, 0, 0, 0, 1); check("down0b", 4'b0000, 1, 0);
    step(1, 0, 0, 0, 1); check("down15b", 4'b1000, 1, 1);
    step(1, 0, 0, 0, 1); check("down14", 4'b1001, 1, 0);

    // asynchronous reset mid-cycle at cnt = 7
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 1, 0, 0, 1);
    check("cnt7", 4'b0100, 1, 0);
    #3 rst = 1'b1;
    #1 check("async_rst", 4'b0000, 0, 0);
    #1 rst = 1'b0;
    step(1, 1, 0, 0, 1); check("after_rst", 4'b0000, 1, 0);
    step(1, 1, 0, 0, 1); check("after_rst1", 4'b0001, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
